// File: rtl/doorlock_pkg.sv
// doorlock_pkg: key codes, LED status encoding and FSM states shared by the door-lock controller.
package doorlock_pkg;
   localparam logic [3:0] KEY_CLR = 4'hA;
   localparam logic [3:0] KEY_ENT = 4'hB;
   localparam logic [1:0] LED_IDLE = 2'd0;
   localparam logic [1:0] LED_OPEN = 2'd1;
   localparam logic [1:0] LED_FAIL = 2'd2;
   localparam logic [1:0] LED_LOCK = 2'd3;
   typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_FAIL, S_LOCKOUT} state_t;
   function automatic logic [1:0] led_of(input state_t s);
      return s == S_OPEN ? LED_OPEN : s == S_FAIL ? LED_FAIL : s == S_LOCKOUT ? LED_LOCK : LED_IDLE;
   endfunction
endpackage

// File: rtl/doorlock_ctrl_tick_timer.sv
// tick_timer: loadable down-counter; expire pulses for the one cycle the count sits at 1.
module tick_timer #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expire
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign expire = cnt == W'(1);
endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad password entry FSM driving the unlock strobe and the LED status code.
module doorlock_ctrl
   import doorlock_pkg::*;
#(
   parameter int          PW_LEN       = 4,
   parameter logic [27:0] PASSWORD     = 28'h1234,
   parameter int          OPEN_TICKS   = 50,
   parameter int          FAIL_TICKS   = 20,
   parameter int          LOCK_TICKS   = 300,
   parameter int          MAX_FAILS    = 3,
   parameter int          IDLE_TIMEOUT = 100
) (
   input  logic       clk_10hz_i,
   input  logic       rst_i,
   input  logic       key_valid_i,
   input  logic [3:0] key_code_i,
   output logic [1:0] led_sig_o,
   output logic       unlock_o,
   output logic [2:0] digit_cnt_o,
   output logic [1:0] fail_cnt_o
);
   localparam int BW = 4 * PW_LEN;
   localparam int TW = $clog2(LOCK_TICKS + 1);
   localparam logic [2:0] PW = 3'(PW_LEN);
   localparam logic [1:0] MF = 2'(MAX_FAILS);
   state_t state, state_n;
   logic [BW-1:0] code_q, code_n;
   logic [2:0] cnt_n;
   logic [1:0] fail_n;
   logic [TW-1:0] tmr_val;
   logic tmr_ld, tmr_exp, idle_ld, idle_exp, pw_ok;
   assign pw_ok = digit_cnt_o == PW && code_q == PASSWORD[BW-1:0];
   // One timer serves OPEN/FAIL/LOCKOUT; inactivity is tracked separately so it survives across them.
   tick_timer #(.W(TW)) u_state_tmr (
      .clk(clk_10hz_i), .rst_n(rst_i), .load(tmr_ld), .value(tmr_val), .expire(tmr_exp)
   );
   tick_timer #(.W(TW)) u_idle_tmr (
      .clk(clk_10hz_i), .rst_n(rst_i), .load(idle_ld), .value(TW'(IDLE_TIMEOUT)), .expire(idle_exp)
   );
   always_comb begin
      state_n = state;
      code_n  = code_q;
      cnt_n   = digit_cnt_o;
      fail_n  = fail_cnt_o;
      tmr_ld  = 1'b0;
      tmr_val = '0;
      idle_ld = 1'b0;
      case (state)
         S_ENTRY:
            if (key_valid_i) begin
               idle_ld = 1'b1;
               if (key_code_i < KEY_CLR) begin
                  if (digit_cnt_o < PW) begin
                     code_n = BW'({code_q, key_code_i});
                     cnt_n  = digit_cnt_o + 3'd1;
                  end
               end else if (key_code_i == KEY_CLR) begin
                  code_n = '0;
                  cnt_n  = '0;
               end else if (key_code_i == KEY_ENT) begin
                  code_n = '0;
                  cnt_n  = '0;
                  tmr_ld = 1'b1;
                  if (pw_ok) begin
                     state_n = S_OPEN;
                     fail_n  = '0;
                     tmr_val = TW'(OPEN_TICKS);
                  end else begin
                     fail_n  = fail_cnt_o + 2'd1;
                     state_n = fail_n == MF ? S_LOCKOUT : S_FAIL;
                     tmr_val = fail_n == MF ? TW'(LOCK_TICKS) : TW'(FAIL_TICKS);
                  end
               end
            end else if (idle_exp && digit_cnt_o != '0) begin
               code_n = '0;
               cnt_n  = '0;
            end
         S_OPEN, S_FAIL:
            state_n = tmr_exp ? S_ENTRY : state;
         S_LOCKOUT:
            if (tmr_exp) begin
               state_n = S_ENTRY;
               fail_n  = '0;
            end
         default:
            state_n = S_ENTRY;
      endcase
   end
   always_ff @(posedge clk_10hz_i or negedge rst_i)
      if (!rst_i) begin
         state       <= S_ENTRY;
         code_q      <= '0;
         digit_cnt_o <= '0;
         fail_cnt_o  <= '0;
         led_sig_o   <= LED_IDLE;
         unlock_o    <= 1'b0;
      end else begin
         state       <= state_n;
         code_q      <= code_n;
         digit_cnt_o <= cnt_n;
         fail_cnt_o  <= fail_n;
         led_sig_o   <= led_of(state_n);
         unlock_o    <= state_n == S_OPEN;
      end
endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl: directed test-plan steps plus random keypad traffic, checked against
// a cycle-level behavioural model built from the lock's rules.
module tb_doorlock_ctrl;
   localparam int          PW_LEN = 4;
   localparam logic [27:0] PASSWORD = 28'h1234;
   localparam int OPEN_T = 50, FAIL_T = 20, LOCK_T = 300, MAXF = 3, IDLE_T = 100;

   logic clk = 1'b0, rst_i = 1'b0, key_valid_i = 1'b0;
   logic [3:0] key_code_i = 4'd0;
   logic [1:0] led_sig_o, fail_cnt_o;
   logic unlock_o;
   logic [2:0] digit_cnt_o;
   int tests = 0, fails = 0;

   // model: display code (0 entry,1 open,2 wrong,3 lockout), remaining hold cycles, digits typed
   int m_mode, m_busy, m_fails, m_idle;
   int m_q[$];
   int pw[$];

   doorlock_ctrl #(
      .PW_LEN(PW_LEN), .PASSWORD(PASSWORD), .OPEN_TICKS(OPEN_T), .FAIL_TICKS(FAIL_T),
      .LOCK_TICKS(LOCK_T), .MAX_FAILS(MAXF), .IDLE_TIMEOUT(IDLE_T)
   ) dut (
      .clk_10hz_i(clk), .rst_i(rst_i), .key_valid_i(key_valid_i), .key_code_i(key_code_i),
      .led_sig_o(led_sig_o), .unlock_o(unlock_o), .digit_cnt_o(digit_cnt_o), .fail_cnt_o(fail_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_mode = 0; m_busy = 0; m_fails = 0; m_idle = 0;
      m_q.delete();
   endtask

   function automatic bit m_match();
      if (m_q.size() != PW_LEN) return 1'b0;
      foreach (m_q[i]) if (m_q[i] != pw[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_edge(input logic v, input int c);
      if (m_busy > 0) begin
         m_busy--;
         m_idle++;
         if (m_busy == 0) begin
            if (m_mode == 3) m_fails = 0;
            m_mode = 0;
         end
      end else if (v) begin
         m_idle = 0;
         if (c < 10) begin
            if (m_q.size() < PW_LEN) m_q.push_back(c);
         end else if (c == 10) m_q.delete();
         else if (c == 11) begin
            if (m_match()) begin
               m_mode = 1; m_busy = OPEN_T; m_fails = 0;
            end else begin
               m_fails++;
               m_mode = m_fails == MAXF ? 3 : 2;
               m_busy = m_fails == MAXF ? LOCK_T : FAIL_T;
            end
            m_q.delete();
         end
      end else begin
         m_idle++;
         if (m_idle == IDLE_T && m_q.size() > 0) m_q.delete();
      end
   endtask

   task automatic chk_all();
      chk("led_sig", 32'(led_sig_o), 32'(m_mode));
      chk("unlock", 32'(unlock_o), 32'(m_mode == 1));
      chk("digit_cnt", 32'(digit_cnt_o), 32'(m_q.size()));
      chk("fail_cnt", 32'(fail_cnt_o), 32'(m_fails));
   endtask

   task automatic step(input logic v, input logic [3:0] c);
      key_valid_i = v;
      key_code_i = c;
      @(posedge clk);
      m_edge(v, int'(c));
      #1;
      chk_all();
      key_valid_i = 1'b0;
   endtask

   task automatic press(input logic [3:0] c);
      step(1'b1, c);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 4'd0);
   endtask

   task automatic enter4(input logic [3:0] a, b, c, d);
      press(a); press(b); press(c); press(d); press(4'hB);
   endtask

   initial begin
      for (int i = 0; i < PW_LEN; i++) pw.push_back(int'((PASSWORD >> (4 * (PW_LEN - 1 - i))) & 28'hF));
      m_reset();
      repeat (2) @(posedge clk);
      #1 chk_all();
      @(negedge clk) rst_i = 1'b1;
      chk("rst_led", 32'(led_sig_o), 0);
      chk("rst_digits", 32'(digit_cnt_o), 0);

      // correct code
      enter4(4'd1, 4'd2, 4'd3, 4'd4);
      chk("open_unlock", 32'(unlock_o), 1);
      chk("open_led", 32'(led_sig_o), 1);
      idle(OPEN_T - 1);
      chk("open_last", 32'(unlock_o), 1);
      idle(1);
      chk("open_done", 32'(unlock_o), 0);
      chk("open_done_led", 32'(led_sig_o), 0);

      // wrong code, then correct clears the failure count
      enter4(4'd1, 4'd2, 4'd3, 4'd5);
      chk("wrong_led", 32'(led_sig_o), 2);
      chk("wrong_cnt", 32'(fail_cnt_o), 1);
      idle(FAIL_T);
      chk("wrong_done", 32'(led_sig_o), 0);
      enter4(4'd1, 4'd2, 4'd3, 4'd4);
      chk("reopen_cnt", 32'(fail_cnt_o), 0);
      idle(OPEN_T);

      // lockout after three failures, keys ignored meanwhile
      enter4(4'd9, 4'd9, 4'd9, 4'd9); idle(FAIL_T);
      enter4(4'd4, 4'd3, 4'd2, 4'd1); idle(FAIL_T);
      enter4(4'd0, 4'd0, 4'd0, 4'd0);
      chk("lock_led", 32'(led_sig_o), 3);
      press(4'd1); press(4'd2);
      chk("lock_keys", 32'(digit_cnt_o), 0);
      idle(LOCK_T - 3);
      chk("lock_last", 32'(led_sig_o), 3);
      idle(1);
      chk("lock_done", 32'(led_sig_o), 0);
      chk("lock_fail_clr", 32'(fail_cnt_o), 0);

      // clear, overflow saturation, short entry
      press(4'd9); press(4'hA);
      chk("clear", 32'(digit_cnt_o), 0);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      chk("saturate", 32'(digit_cnt_o), 4);
      press(4'hB);
      chk("ovf_open", 32'(unlock_o), 1);
      idle(OPEN_T);
      press(4'd1); press(4'd2); press(4'hB);
      chk("short_fail", 32'(led_sig_o), 2);
      idle(FAIL_T);

      // inactivity clear exactly at the 100th key-free edge
      press(4'd1); press(4'd2);
      idle(IDLE_T - 1);
      chk("idle_before", 32'(digit_cnt_o), 2);
      idle(1);
      chk("idle_clear", 32'(digit_cnt_o), 0);
      chk("idle_fails", 32'(fail_cnt_o), 1);

      // asynchronous reset mid-OPEN
      enter4(4'd1, 4'd2, 4'd3, 4'd4);
      idle(10);
      #2 rst_i = 1'b0;
      #1;
      chk("arst_unlock", 32'(unlock_o), 0);
      chk("arst_led", 32'(led_sig_o), 0);
      m_reset();
      @(posedge clk);
      #1 chk_all();
      @(negedge clk) rst_i = 1'b1;

      // random traffic
      for (int s = 0; s < 60; s++) begin
         case ($urandom_range(0, 3))
            0: begin
               foreach (pw[i]) press(4'(pw[i]));
               press(4'hB);
            end
            1: repeat ($urandom_range(5, 40)) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            2: idle($urandom_range(0, 120));
            default: begin
               repeat ($urandom_range(0, 6)) press(4'($urandom_range(0, 9)));
               step(1'($urandom_range(0, 1)), 4'hB);
            end
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
